// File: rtl/cam_param.sv
// ---------------------------------------------------------------------------
// cam_param -- parametrised content-addressable memory (lookup / dedup table)
//
// Operations: search, insert (with duplicate check), delete, clear. The entry
// array is valid-tracked. Each request is answered by exactly one response.
// Requests use a valid/ready handshake, and so do responses.
//
// Timing: a request is accepted in IDLE. Search, insert and delete spend one
// MATCH cycle and then enter RESP. Clear sweeps one entry per cycle for DEPTH
// cycles and then enters RESP. RESP holds until rsp_ready is seen.
//
// Parameters:
//   DATA_W  key width in bits
//   DEPTH   number of entries (>= 2)
//   IDX_W   index width, 2**IDX_W >= DEPTH
//
// Ports:
//   clk        clock, all logic on the rising edge
//   rst_n      synchronous active-low reset
//   req_valid  request present
//   req_ready  request accepted this cycle when valid (high only in IDLE)
//   req_op     00 search, 01 insert, 10 delete, 11 clear
//   req_data   key (ignored for clear)
//   rsp_valid  response present, held until rsp_ready
//   rsp_ready  consumer takes the response
//   rsp_hit    key matched a valid entry
//   rsp_idx    matched, written or freed index (0 when none)
//   rsp_full   insert refused or replaced because the table was full
//   count      number of valid entries
//
// Optional feature, macro CAM_REPLACE_EN:
//   Defined   : an insert miss on a full table overwrites the entry at a
//               round-robin victim pointer. Clear resets the pointer to 0.
//   Undefined : an insert miss on a full table is refused.
// ---------------------------------------------------------------------------
module cam_param #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int IDX_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [DATA_W-1:0] req_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_hit,
  output logic [IDX_W-1:0]  rsp_idx,
  output logic              rsp_full,
  output logic [IDX_W:0]    count
);

  typedef enum logic [1:0] {
    OP_SEARCH = 2'b00,
    OP_INSERT = 2'b01,
    OP_DELETE = 2'b10,
    OP_CLEAR  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MATCH,
    S_CLEAR,
    S_RESP
  } state_e;

  localparam logic [IDX_W:0]   FULL_CNT = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W:0]   CNT_ONE  = (IDX_W+1)'(1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  state_e              state_q, state_d;
  op_e                 op_q;
  logic [DATA_W-1:0]   key_q;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DEPTH-1:0]    valid_q;
  logic [IDX_W:0]      count_q;
  logic [IDX_W-1:0]    clr_idx_q;
  logic                rsp_hit_q;
  logic                rsp_full_q;
  logic [IDX_W-1:0]    rsp_idx_q;

  logic                hit;
  logic [IDX_W-1:0]    hit_idx;
  logic [IDX_W-1:0]    free_idx;
  logic                full;

`ifdef CAM_REPLACE_EN
  logic [IDX_W-1:0]    victim_q;
`endif

  // -------------------------------------------------------------------------
  // Match and free-slot search. The loops scan from the top index down, so
  // the lowest qualifying index is the one assigned last. Invalid entries
  // never match, even though reset leaves their data at 0.
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before the loop. Without it, a
    // path that does not assign the variable would infer a latch.
    hit      = 1'b0;
    hit_idx  = '0;
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (valid_q[i] && (mem_q[i] == key_q)) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
      if (!valid_q[i]) begin
        free_idx = IDX_W'(i);
      end
    end
  end

  assign full = (count_q == FULL_CNT);

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking (<=) assignments. All flops
    // then update together from values sampled before the edge.
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          state_d = (op_e'(req_op) == OP_CLEAR) ? S_CLEAR : S_MATCH;
        end
      end
      S_MATCH: state_d = S_RESP;
      S_CLEAR: begin
        if (clr_idx_q == LAST_IDX) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs
  // -------------------------------------------------------------------------
  always_comb begin
    req_ready = (state_q == S_IDLE);
    rsp_valid = (state_q == S_RESP);
  end

  assign rsp_hit  = rsp_hit_q;
  assign rsp_idx  = rsp_idx_q;
  assign rsp_full = rsp_full_q;
  assign count    = count_q;

  // -------------------------------------------------------------------------
  // Datapath: request capture, commit in MATCH, sweep in CLEAR.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the entry array is reset explicitly, so reset leaves the table
      // in a known state. This also aborts a clear sweep that is in progress.
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      valid_q    <= '0;
      count_q    <= '0;
      clr_idx_q  <= '0;
      op_q       <= OP_SEARCH;
      key_q      <= '0;
      rsp_hit_q  <= 1'b0;
      rsp_idx_q  <= '0;
      rsp_full_q <= 1'b0;
`ifdef CAM_REPLACE_EN
      victim_q   <= '0;
`endif
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            op_q      <= op_e'(req_op);
            key_q     <= req_data;
            clr_idx_q <= '0;
          end
        end

        S_MATCH: begin
          rsp_hit_q  <= 1'b0;
          rsp_idx_q  <= '0;
          rsp_full_q <= 1'b0;
          case (op_q)
            OP_SEARCH: begin
              rsp_hit_q <= hit;
              rsp_idx_q <= hit_idx;
            end
            OP_INSERT: begin
              if (hit) begin
                rsp_hit_q <= 1'b1;
                rsp_idx_q <= hit_idx;
              end else if (!full) begin
                mem_q[free_idx]   <= key_q;
                valid_q[free_idx] <= 1'b1;
                rsp_idx_q         <= free_idx;
                count_q           <= count_q + CNT_ONE;
              end else begin
                rsp_full_q <= 1'b1;
`ifdef CAM_REPLACE_EN
                // Every entry is valid here, so only the data is overwritten.
                // count is unchanged.
                mem_q[victim_q] <= key_q;
                rsp_idx_q       <= victim_q;
                victim_q        <= (victim_q == LAST_IDX) ? '0 : victim_q + IDX_ONE;
`endif
              end
            end
            OP_DELETE: begin
              if (hit) begin
                valid_q[hit_idx] <= 1'b0;
                count_q          <= count_q - CNT_ONE;
                rsp_hit_q        <= 1'b1;
                rsp_idx_q        <= hit_idx;
              end
            end
            default: ;
          endcase
        end

        S_CLEAR: begin
          valid_q[clr_idx_q] <= 1'b0;
          if (clr_idx_q == LAST_IDX) begin
            count_q    <= '0;
            rsp_hit_q  <= 1'b0;
            rsp_idx_q  <= '0;
            rsp_full_q <= 1'b0;
`ifdef CAM_REPLACE_EN
            victim_q   <= '0;
`endif
          end else begin
            clr_idx_q <= clr_idx_q + IDX_ONE;
          end
        end

        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cam_param.sv
// ---------------------------------------------------------------------------
// tb_cam_param -- self-checking bench for cam_param (default parameters).
// Expected responses are pushed to a scoreboard queue when a request is
// issued. They are popped and compared when rsp_valid is observed. Inputs
// are driven on the falling edge, and outputs are sampled on the falling
// edge. Build with +define+CAM_REPLACE_EN to exercise replacement.
// ---------------------------------------------------------------------------
module tb_cam_param;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int IDX_W  = 4;

  localparam logic [1:0] OP_SEARCH = 2'b00;
  localparam logic [1:0] OP_INSERT = 2'b01;
  localparam logic [1:0] OP_DELETE = 2'b10;
  localparam logic [1:0] OP_CLEAR  = 2'b11;

  logic              clk;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_op;
  logic [DATA_W-1:0] req_data;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_hit;
  logic [IDX_W-1:0]  rsp_idx;
  logic              rsp_full;
  logic [IDX_W:0]    count;

  typedef struct {
    logic             hit;
    logic [IDX_W-1:0] idx;
    logic             full;
    logic [IDX_W:0]   cnt;
    int               lat;
  } exp_t;

  exp_t sb_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  cam_param #(.DATA_W(DATA_W), .DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_data  (req_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_hit   (rsp_hit),
    .rsp_idx   (rsp_idx),
    .rsp_full  (rsp_full),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Issues one request and pushes its expected response. The bench waits for
  // rsp_valid, pops the expectation and compares. It then holds rsp_ready low
  // for 'hold' cycles and checks that the response stays stable. Cycle 0 is
  // the acceptance cycle, so the latency is the cycle in which rsp_valid is
  // first seen.
  task automatic send(input string name, input logic [1:0] op,
                      input logic [DATA_W-1:0] data, input logic e_hit,
                      input int e_idx, input logic e_full, input int e_cnt,
                      input int hold);
    exp_t e;
    exp_t x;
    int   wait_cnt;
    int   cyc;
    e.hit  = e_hit;
    e.idx  = IDX_W'(e_idx);
    e.full = e_full;
    e.cnt  = (IDX_W+1)'(e_cnt);
    e.lat  = (op == OP_CLEAR) ? DEPTH + 1 : 2;
    sb_q.push_back(e);

    @(negedge clk);
    req_valid = 1'b1;
    req_op    = op;
    req_data  = data;
    wait_cnt  = 0;
    while (!req_ready && wait_cnt < 50) begin
      @(negedge clk);
      wait_cnt++;
    end
    vectors++;
    if (!req_ready) begin
      $display("FAIL %s accept: req_ready=%0b required 1", name, req_ready);
      miscompares++;
      req_valid = 1'b0;
      void'(sb_q.pop_front());
      return;
    end
    @(negedge clk);
    req_valid = 1'b0;
    req_data  = '0;
    cyc = 1;
    while (!rsp_valid && cyc < DEPTH + 20) begin
      @(negedge clk);
      cyc++;
    end
    x = sb_q.pop_front();

    vectors++;
    if (cyc !== x.lat) begin
      $display("FAIL %s latency: got %0d required %0d", name, cyc, x.lat);
      miscompares++;
    end
    if (!rsp_valid) return;

    vectors++;
    if (rsp_hit !== x.hit) begin
      $display("FAIL %s hit: got %0b required %0b", name, rsp_hit, x.hit);
      miscompares++;
    end
    vectors++;
    if (rsp_idx !== x.idx) begin
      $display("FAIL %s idx: got %0d required %0d", name, rsp_idx, x.idx);
      miscompares++;
    end
    vectors++;
    if (rsp_full !== x.full) begin
      $display("FAIL %s full: got %0b required %0b", name, rsp_full, x.full);
      miscompares++;
    end
    vectors++;
    if (count !== x.cnt) begin
      $display("FAIL %s count: got %0d required %0d", name, count, x.cnt);
      miscompares++;
    end

    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      vectors++;
      if ({rsp_valid, rsp_hit, rsp_idx, rsp_full, req_ready} !==
          {1'b1, x.hit, x.idx, x.full, 1'b0}) begin
        $display("FAIL %s hold%0d: v=%0b h=%0b i=%0d f=%0b rdy=%0b required v=1 h=%0b i=%0d f=%0b rdy=0",
                 name, i, rsp_valid, rsp_hit, rsp_idx, rsp_full, req_ready, x.hit, x.idx, x.full);
        miscompares++;
      end
    end

    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    vectors++;
    if ({rsp_valid, req_ready} !== 2'b01) begin
      $display("FAIL %s release: rsp_valid=%0b req_ready=%0b required 0/1", name, rsp_valid, req_ready);
      miscompares++;
    end
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if ({rsp_valid, req_ready, rsp_hit, rsp_idx, rsp_full, count} !==
        {1'b0, 1'b1, 1'b0, {IDX_W{1'b0}}, 1'b0, {(IDX_W+1){1'b0}}}) begin
      $display("FAIL reset_state: v=%0b rdy=%0b h=%0b i=%0d f=%0b cnt=%0d required 0 1 0 0 0 0",
               rsp_valid, req_ready, rsp_hit, rsp_idx, rsp_full, count);
      miscompares++;
    end
    send("search_zero", OP_SEARCH, 8'h00, 1'b0, 0, 1'b0, 0, 0);
  endtask

  task automatic test_insert_dup();
    do_reset();
    send("ins_5a",     OP_INSERT, 8'h5A, 1'b0, 0, 1'b0, 1, 0);
    send("ins_3c",     OP_INSERT, 8'h3C, 1'b0, 1, 1'b0, 2, 0);
    send("ins_5a_dup", OP_INSERT, 8'h5A, 1'b1, 0, 1'b0, 2, 0);
  endtask

  task automatic test_delete_reuse();
    do_reset();
    send("ins_5a",     OP_INSERT, 8'h5A, 1'b0, 0, 1'b0, 1, 0);
    send("ins_3c",     OP_INSERT, 8'h3C, 1'b0, 1, 1'b0, 2, 0);
    send("del_5a",     OP_DELETE, 8'h5A, 1'b1, 0, 1'b0, 1, 0);
    send("del_miss",   OP_DELETE, 8'h5A, 1'b0, 0, 1'b0, 1, 0);
    send("srch_5a",    OP_SEARCH, 8'h5A, 1'b0, 0, 1'b0, 1, 0);
    send("ins_77",     OP_INSERT, 8'h77, 1'b0, 0, 1'b0, 2, 0);
    send("srch_3c",    OP_SEARCH, 8'h3C, 1'b1, 1, 1'b0, 2, 0);
  endtask

  task automatic fill_table(input logic [DATA_W-1:0] base);
    for (int i = 0; i < DEPTH; i++) begin
      send("fill", OP_INSERT, base + DATA_W'(i), 1'b0, i, 1'b0, i + 1, 0);
    end
  endtask

  task automatic test_full();
    do_reset();
    fill_table(8'h10);
    send("dup_full", OP_INSERT, 8'h15, 1'b1, 5, 1'b0, DEPTH, 0);
`ifdef CAM_REPLACE_EN
    send("ins_99_repl", OP_INSERT, 8'h99, 1'b0, 0, 1'b1, DEPTH, 0);
    send("srch_10",     OP_SEARCH, 8'h10, 1'b0, 0, 1'b0, DEPTH, 0);
    send("srch_99",     OP_SEARCH, 8'h99, 1'b1, 0, 1'b0, DEPTH, 0);
    send("ins_aa_repl", OP_INSERT, 8'hAA, 1'b0, 1, 1'b1, DEPTH, 0);
    send("clear",       OP_CLEAR,  8'h00, 1'b0, 0, 1'b0, 0, 0);
    fill_table(8'h40);
    send("ins_cc_repl", OP_INSERT, 8'hCC, 1'b0, 0, 1'b1, DEPTH, 0);
`else
    send("ins_99_full", OP_INSERT, 8'h99, 1'b0, 0, 1'b1, DEPTH, 0);
    send("srch_99",     OP_SEARCH, 8'h99, 1'b0, 0, 1'b0, DEPTH, 0);
    send("srch_10",     OP_SEARCH, 8'h10, 1'b1, 0, 1'b0, DEPTH, 0);
    send("srch_1f",     OP_SEARCH, 8'h1F, 1'b1, 15, 1'b0, DEPTH, 0);
`endif
  endtask

  task automatic test_hold_clear();
    do_reset();
    send("ins_42",      OP_INSERT, 8'h42, 1'b0, 0, 1'b0, 1, 0);
    send("srch_42_hold", OP_SEARCH, 8'h42, 1'b1, 0, 1'b0, 1, 5);
    send("clear",       OP_CLEAR,  8'h00, 1'b0, 0, 1'b0, 0, 0);
    send("srch_42_gone", OP_SEARCH, 8'h42, 1'b0, 0, 1'b0, 0, 0);
  endtask

  task automatic test_reset_mid_clear();
    int wait_cnt;
    do_reset();
    fill_table(8'h20);
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = OP_CLEAR;
    req_data  = '0;
    wait_cnt  = 0;
    while (!req_ready && wait_cnt < 50) begin
      @(negedge clk);
      wait_cnt++;
    end
    @(negedge clk);
    req_valid = 1'b0;
    // Cycle 1 sweeps index 0, so cycle 8 sweeps index 7.
    repeat (7) @(negedge clk);
    vectors++;
    if ({rsp_valid, req_ready} !== 2'b00) begin
      $display("FAIL mid_clear_busy: rsp_valid=%0b req_ready=%0b required 0/0", rsp_valid, req_ready);
      miscompares++;
    end
    rst_n = 1'b0;
    @(negedge clk);
    vectors++;
    if ({rsp_valid, req_ready, count} !== {1'b0, 1'b1, {(IDX_W+1){1'b0}}}) begin
      $display("FAIL mid_clear_reset: v=%0b rdy=%0b cnt=%0d required 0 1 0", rsp_valid, req_ready, count);
      miscompares++;
    end
    rst_n = 1'b1;
    send("srch_20", OP_SEARCH, 8'h20, 1'b0, 0, 1'b0, 0, 0);
    send("srch_28", OP_SEARCH, 8'h28, 1'b0, 0, 1'b0, 0, 0);
    send("srch_2f", OP_SEARCH, 8'h2F, 1'b0, 0, 1'b0, 0, 0);
    send("srch_00", OP_SEARCH, 8'h00, 1'b0, 0, 1'b0, 0, 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_op    = OP_SEARCH;
    req_data  = '0;
    rsp_ready = 1'b0;
    test_reset();
    test_insert_dup();
    test_delete_reuse();
    test_full();
    test_hold_clear();
    test_reset_mid_clear();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
